pdm_modulator: RTL and testbench

- First-order sigma-delta modulator. Turns signed 8-bit PCM samples into a 1-bit PDM stream.
- It is the transmit-side counterpart of the PDM-to-PCM sampler. The PDM stream drives an audio pin, or loops back into the analyzer input for self-test.
- Samples arrive through a valid/ready handshake into a small FIFO. Each sample is held for OSR bit periods, and bit periods are paced by an external tick strobe.

---
 rtl/pdm_modulator.sv | 114 +++++++++++
 tb/tb_pdm_modulator.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pdm_modulator.sv
// First-order sigma-delta modulator: signed PCM samples in through a small FIFO,
// 1-bit PDM out, one bit per external tick, OSR bits per sample.
module pdm_modulator #(
   parameter int OSR        = 16,
   parameter int FIFO_DEPTH = 4,
   parameter int DATA_W     = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          tick,
   input  logic                          enable,
   input  logic                          s_valid,
   output logic                          s_ready,
   input  logic [DATA_W-1:0]             s_data,
   input  logic                          underrun_clr,
   output logic                          pdm_out,
   output logic                          underrun,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int LW = $clog2(FIFO_DEPTH) + 1;
   localparam int CW = (OSR > 1) ? $clog2(OSR) : 1;
   localparam logic [DATA_W-1:0] OFFSET = {1'b1, {(DATA_W-1){1'b0}}};

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [LW-1:0]     level;
   logic              full;
   logic              empty;
   logic              push;
   logic              pop;

   logic [CW-1:0]     cnt;
   logic [DATA_W-1:0] cur;
   logic [DATA_W-1:0] acc;
   logic              run_tick;
   logic              slot_start;
   logic [DATA_W-1:0] cur_next;
   logic [DATA_W-1:0] u;
   logic [DATA_W:0]   sum;

   assign full       = (level == LW'(FIFO_DEPTH));
   assign empty      = (level == '0);
   assign s_ready    = ~full;
   assign fifo_level = level;

   assign run_tick   = tick & enable;
   assign slot_start = run_tick & (cnt == '0);
   assign push       = s_valid & ~full;
   assign pop        = slot_start & ~empty;

   // A freshly popped sample is modulated on the very tick that pops it.
   assign cur_next = pop ? mem[rd_ptr] : cur;
   assign u        = cur_next ^ OFFSET;
   assign sum      = {1'b0, acc} + {1'b0, u};

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= s_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            level <= level + 1'b1;
         end else if (pop && !push) begin
            level <= level - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         cur     <= '0;
         acc     <= '0;
         pdm_out <= 1'b0;
      end else if (!enable) begin
         // cur survives a pause so a resumed stream without new data repeats it.
         cnt     <= '0;
         acc     <= '0;
         pdm_out <= 1'b0;
      end else if (tick) begin
         cnt     <= (cnt == CW'(OSR - 1)) ? '0 : cnt + 1'b1;
         cur     <= cur_next;
         acc     <= sum[DATA_W-1:0];
         pdm_out <= sum[DATA_W];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         underrun <= 1'b0;
      end else if (slot_start && empty) begin
         underrun <= 1'b1;
      end else if (underrun_clr) begin
         underrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pdm_modulator.sv
// Directed bench for pdm_modulator: ones density per slot, FIFO ordering/full,
// underrun stickiness and asynchronous reset.
module tb_pdm_modulator;

   logic       clk;
   logic       rst_n;
   logic       tick;
   logic       enable;
   logic       s_valid;
   logic       s_ready;
   logic [7:0] s_data;
   logic       underrun_clr;
   logic       pdm_out;
   logic       underrun;
   logic [2:0] fifo_level;

   int n_checks;
   int n_errors;

   pdm_modulator #(.OSR(16), .FIFO_DEPTH(4), .DATA_W(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .tick         (tick),
      .enable       (enable),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .s_data       (s_data),
      .underrun_clr (underrun_clr),
      .pdm_out      (pdm_out),
      .underrun     (underrun),
      .fifo_level   (fifo_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // All helpers start and end at a falling edge.
   task automatic push_sample(input logic [7:0] d);
      s_valid = 1'b1;
      s_data  = d;
      @(negedge clk);
      s_valid = 1'b0;
   endtask

   task automatic do_tick(input int gap, output logic b);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      b = pdm_out;
      repeat (gap - 1) @(negedge clk);
   endtask

   task automatic run_ticks(input int n, input int gap, output int ones);
      logic b;
      ones = 0;
      for (int i = 0; i < n; i++) begin
         do_tick(gap, b);
         ones += int'(b);
      end
   endtask

   task automatic pause();
      enable = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   initial begin
      logic b;
      int   ones;
      int   ones2;

      n_checks     = 0;
      n_errors     = 0;
      rst_n        = 1'b0;
      tick         = 1'b0;
      enable       = 1'b0;
      s_valid      = 1'b0;
      s_data       = '0;
      underrun_clr = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      chk("rst_level", int'(fifo_level), 0);
      chk("rst_ready", int'(s_ready), 1);
      chk("rst_pdm", int'(pdm_out), 0);
      chk("rst_underrun", int'(underrun), 0);

      // Max sample 0x7F (u=255): 0 then fifteen ones.
      push_sample(8'h7F);
      chk("max_level", int'(fifo_level), 1);
      enable = 1'b1;
      do_tick(1, b);
      chk("max_first_bit", int'(b), 0);
      chk("max_popped_level", int'(fifo_level), 0);
      run_ticks(15, 1, ones);
      chk("max_ones", ones, 15);
      chk("max_no_underrun", int'(underrun), 0);
      do_tick(1, b);
      chk("max_tick17_underrun", int'(underrun), 1);
      pause();
      chk("pause_pdm_zero", int'(pdm_out), 0);
      underrun_clr = 1'b1;
      @(negedge clk);
      underrun_clr = 1'b0;
      chk("clr_underrun", int'(underrun), 0);

      // Mid-scale 0x00 (u=128), ticks 3 cycles apart: 0,1,0,1...
      push_sample(8'h00);
      enable = 1'b1;
      ones = 0;
      for (int i = 0; i < 16; i++) begin
         do_tick(1, b);
         ones += int'(b);
         if (i < 4) chk("mid_bit", int'(b), i % 2);
         @(negedge clk);
         @(negedge clk);
         if (i < 4) chk("mid_hold", int'(pdm_out), i % 2);
      end
      chk("mid_ones", ones, 8);
      pause();

      // Min sample 0x80 (u=0), then 0x40 (u=192).
      push_sample(8'h80);
      push_sample(8'h40);
      chk("min_level", int'(fifo_level), 2);
      enable = 1'b1;
      run_ticks(16, 1, ones);
      chk("min_ones", ones, 0);
      run_ticks(16, 1, ones);
      chk("q40_ones", ones, 12);
      pause();

      // FIFO full: four samples while paused, a fifth held until the first pop.
      push_sample(8'hC0);
      push_sample(8'h40);
      push_sample(8'h00);
      push_sample(8'hE0);
      chk("full_level", int'(fifo_level), 4);
      chk("full_ready", int'(s_ready), 0);
      s_valid = 1'b1;
      s_data  = 8'h20;
      @(negedge clk);
      chk("full_blocked_level", int'(fifo_level), 4);
      enable = 1'b1;
      tick   = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      b    = pdm_out;
      chk("pop_level", int'(fifo_level), 3);
      chk("pop_ready", int'(s_ready), 1);
      @(negedge clk);
      s_valid = 1'b0;
      chk("refill_level", int'(fifo_level), 4);
      run_ticks(15, 1, ones);
      chk("slot_c0_ones", ones + int'(b), 4);
      run_ticks(16, 1, ones);
      chk("slot_40_ones", ones, 12);
      run_ticks(16, 1, ones);
      chk("slot_00_ones", ones, 8);
      run_ticks(16, 1, ones);
      chk("slot_e0_ones", ones, 6);
      run_ticks(16, 1, ones);
      chk("slot_20_ones", ones, 10);
      chk("drained_level", int'(fifo_level), 0);
      chk("drained_no_underrun", int'(underrun), 0);
      pause();

      // Underrun: one sample 0x20 (u=160) over 32 ticks.
      push_sample(8'h20);
      enable = 1'b1;
      run_ticks(16, 1, ones);
      chk("ur_slot1_ones", ones, 10);
      chk("ur_slot1_flag", int'(underrun), 0);
      do_tick(1, b);
      chk("ur_tick17_flag", int'(underrun), 1);
      run_ticks(15, 1, ones2);
      chk("ur_slot2_ones", ones2 + int'(b), 10);
      underrun_clr = 1'b1;
      @(negedge clk);
      underrun_clr = 1'b0;
      chk("ur_clr", int'(underrun), 0);
      underrun_clr = 1'b1;
      do_tick(1, b);
      underrun_clr = 1'b0;
      chk("ur_set_wins", int'(underrun), 1);
      pause();
      underrun_clr = 1'b1;
      @(negedge clk);
      underrun_clr = 1'b0;
      chk("ur_clr2", int'(underrun), 0);

      // Reset mid-slot with samples queued.
      push_sample(8'h7F);
      push_sample(8'h7F);
      push_sample(8'h7F);
      enable = 1'b1;
      run_ticks(5, 1, ones);
      chk("pre_rst_ones", ones, 4);
      chk("pre_rst_pdm", int'(pdm_out), 1);
      chk("pre_rst_level", int'(fifo_level), 2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_pdm", int'(pdm_out), 0);
      chk("async_rst_level", int'(fifo_level), 0);
      chk("async_rst_ready", int'(s_ready), 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      do_tick(1, b);
      chk("post_rst_underrun", int'(underrun), 1);
      chk("post_rst_bit", int'(b), 0);
      chk("post_rst_level", int'(fifo_level), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
